// File: rtl/m_datapath_if.sv
// Interface bundling the controller-to-datapath select bus, the PCPI operands and the result.
// The controller (or a testbench) drives the selects through the master modport.
// The datapath consumes them through the slave modport.
interface m_datapath_if;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  mux_R;
  logic [1:0]  mux_D;
  logic [1:0]  mux_Z;
  logic [1:0]  mux_multA;
  logic [1:0]  mux_multB;
  logic        mux_div_rem;
  logic [2:0]  mux_out;
  logic [31:0] pcpi_rd;

  modport master (
    output rs1, rs2, mux_R, mux_D, mux_Z, mux_multA, mux_multB, mux_div_rem, mux_out,
    input  pcpi_rd
  );

  modport slave (
    input  rs1, rs2, mux_R, mux_D, mux_Z, mux_multA, mux_multB, mux_div_rem, mux_out,
    output pcpi_rd
  );
endinterface

// File: rtl/m_datapath.sv
// m_datapath: arithmetic datapath of the PCPI M-extension coprocessor.
// It holds the remainder (R), divisor (D) and quotient (Z) registers, runs a 32-step restoring
// divider and a 33x33 signed multiplier, and drives pcpi_rd. There is no FSM here; every step is
// steered by the select codes coming from m_controller.
// Optional build macro M_DP_ASSERT_EN: when defined, SVA checks flag illegal or unknown select
// codes, SUB_KEEP without SHR, and runs of more than 32 SHL_ADD cycles.
module m_datapath #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          resetn,
  m_datapath_if.slave   bus
);

  // Select encodings shared with the controller
  localparam logic [2:0] R_KEEP     = 3'd0;
  localparam logic [2:0] R_A        = 3'd1;
  localparam logic [2:0] R_A_NEG    = 3'd2;
  localparam logic [2:0] R_SUB_KEEP = 3'd3;

  localparam logic [1:0] D_KEEP     = 2'd0;
  localparam logic [1:0] D_B        = 2'd1;
  localparam logic [1:0] D_B_NEG    = 2'd2;
  localparam logic [1:0] D_SHR      = 2'd3;

  localparam logic [1:0] Z_KEEP     = 2'd0;
  localparam logic [1:0] Z_ZERO     = 2'd1;
  localparam logic [1:0] Z_SHL_ADD  = 2'd2;

  localparam logic [1:0] OP_ZERO     = 2'd0;
  localparam logic [1:0] OP_UNSIGNED = 2'd1;
  localparam logic [1:0] OP_SIGNED   = 2'd2;

  localparam logic [2:0] OUT_ZERO        = 3'd0;
  localparam logic [2:0] OUT_MULT_LOWER  = 3'd1;
  localparam logic [2:0] OUT_MULT_UPPER  = 3'd2;
  localparam logic [2:0] OUT_DIV_REM     = 3'd3;
  localparam logic [2:0] OUT_DIV_REM_NEG = 3'd4;

  // Only the 32-bit datapath exists; anything else must fail at elaboration
  if (XLEN != 32) begin : g_xlenCheck
    $error("m_datapath: only XLEN=32 is supported");
  end

  logic [63:0] r_rem;
  logic [63:0] r_div;
  logic [31:0] r_quo;
  logic [63:0] r_prod;
  logic [31:0] r_divRem;
  logic        r_dz;
  logic        r_drZ;

  logic        w_geq;
  logic [31:0] w_negA;
  logic [31:0] w_negB;
  logic [31:0] w_dvdB;
  logic [32:0] w_opA;
  logic [32:0] w_opB;
  logic [63:0] w_prod;
  logic [31:0] w_negDr;

  // One compare serves both the conditional subtract and the quotient bit of this step
  assign w_geq   = (r_rem >= r_div);
  assign w_negA  = 32'd0 - bus.rs1;
  assign w_negB  = 32'd0 - bus.rs2;
  assign w_dvdB  = r_div[62:31];
  assign w_negDr = 32'd0 - r_divRem;

  // Multiplier operands; ZERO and illegal codes isolate the operand to 0
  always_comb begin
    w_opA = 33'd0;
    w_opB = 33'd0;
    case (bus.mux_multA)
      OP_UNSIGNED: w_opA = {1'b0, r_rem[31:0]};
      OP_SIGNED:   w_opA = {r_rem[31], r_rem[31:0]};
      default:     w_opA = 33'd0;
    endcase
    case (bus.mux_multB)
      OP_UNSIGNED: w_opB = {1'b0, w_dvdB};
      OP_SIGNED:   w_opB = {w_dvdB[31], w_dvdB};
      default:     w_opB = 33'd0;
    endcase
  end

  // Sign-extending both 33-bit operands to 64 bits makes the low 64 product bits exact
  assign w_prod = {{31{w_opA[32]}}, w_opA} * {{31{w_opB[32]}}, w_opB};

  // Remainder register: operand load or one conditional-subtract step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem <= 64'd0;
    end else begin
      case (bus.mux_R)
        R_A:        r_rem <= {32'd0, bus.rs1};
        R_A_NEG:    r_rem <= {32'd0, w_negA};
        R_SUB_KEEP: if (w_geq) r_rem <= r_rem - r_div;
        default:    r_rem <= r_rem;
      endcase
    end
  end

  // Divisor register: loads the divisor pre-shifted by 31 and walks it right one bit per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= 64'd0;
      r_dz  <= 1'b0;
    end else begin
      case (bus.mux_D)
        D_B: begin
          r_div <= {1'b0, bus.rs2, 31'd0};
          r_dz  <= (bus.rs2 == 32'd0);
        end
        D_B_NEG: begin
          r_div <= {1'b0, w_negB, 31'd0};
          r_dz  <= (bus.rs2 == 32'd0);
        end
        D_SHR:   r_div <= r_div >> 1;
        default: r_div <= r_div;
      endcase
    end
  end

  // Quotient register: cleared on load, then shifts in one quotient bit per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_quo <= 32'd0;
    end else begin
      case (bus.mux_Z)
        Z_ZERO:    r_quo <= 32'd0;
        Z_SHL_ADD: r_quo <= {r_quo[30:0], w_geq};
        default:   r_quo <= r_quo;
      endcase
    end
  end

  // Product and divide-result registers capture every cycle so DONE sees the SELECT-cycle choice
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prod   <= 64'd0;
      r_divRem <= 32'd0;
      r_drZ    <= 1'b0;
    end else begin
      r_prod   <= w_prod;
      r_divRem <= bus.mux_div_rem ? r_quo : r_rem[31:0];
      r_drZ    <= bus.mux_div_rem;
    end
  end

  // Result mux; a quotient read after a zero divisor returns all ones
  always_comb begin
    bus.pcpi_rd = 32'd0;
    case (bus.mux_out)
      OUT_MULT_LOWER:  bus.pcpi_rd = r_prod[31:0];
      OUT_MULT_UPPER:  bus.pcpi_rd = r_prod[63:32];
      OUT_DIV_REM:     bus.pcpi_rd = (r_dz && r_drZ) ? 32'hFFFF_FFFF : r_divRem;
      OUT_DIV_REM_NEG: bus.pcpi_rd = (r_dz && r_drZ) ? 32'hFFFF_FFFF : w_negDr;
      default:         bus.pcpi_rd = 32'd0;
    endcase
  end

`ifdef M_DP_ASSERT_EN
  logic [5:0] r_shlRun;

  // Length of the current run of consecutive SHL_ADD cycles, saturating above 32
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shlRun <= 6'd0;
    end else if (bus.mux_Z == Z_SHL_ADD) begin
      if (r_shlRun != 6'd33) r_shlRun <= r_shlRun + 6'd1;
    end else begin
      r_shlRun <= 6'd0;
    end
  end

  a_selKnown: assert property (@(posedge clk) disable iff (!resetn)
    !$isunknown({bus.mux_R, bus.mux_D, bus.mux_Z, bus.mux_multA, bus.mux_multB,
                 bus.mux_div_rem, bus.mux_out}))
    else $error("m_datapath: unknown select value");

  a_selLegal: assert property (@(posedge clk) disable iff (!resetn)
    (bus.mux_R <= R_SUB_KEEP) && (bus.mux_Z != 2'd3) && (bus.mux_multA != 2'd3) &&
    (bus.mux_multB != 2'd3) && (bus.mux_out <= OUT_DIV_REM_NEG))
    else $error("m_datapath: illegal select code");

  a_subWithShr: assert property (@(posedge clk) disable iff (!resetn)
    (bus.mux_R == R_SUB_KEEP) |-> (bus.mux_D == D_SHR))
    else $error("m_datapath: SUB_KEEP without SHR");

  a_shlRunLen: assert property (@(posedge clk) disable iff (!resetn)
    !((r_shlRun >= 6'd32) && (bus.mux_Z == Z_SHL_ADD)))
    else $error("m_datapath: more than 32 consecutive SHL_ADD cycles");
`endif

endmodule

// File: tb/tb_m_datapath.sv
// Directed testbench for m_datapath: multiply, divide, divide-by-zero, overflow,
// illegal select codes and asynchronous reset in the middle of a division.
module tb_m_datapath;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  m_datapath_if dpIf ();

  m_datapath dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dpIf)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every select of the bus in one go
  task automatic applyStimulus(input logic [2:0] rSel, input logic [1:0] dSel,
                               input logic [1:0] zSel, input logic [1:0] aSel,
                               input logic [1:0] bSel, input logic drSel,
                               input logic [2:0] outSel);
    dpIf.mux_R       = rSel;
    dpIf.mux_D       = dSel;
    dpIf.mux_Z       = zSel;
    dpIf.mux_multA   = aSel;
    dpIf.mux_multB   = bSel;
    dpIf.mux_div_rem = drSel;
    dpIf.mux_out     = outSel;
  endtask

  // One comparison with failure accounting
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load operands: R from rs1 (A or A_NEG), D from rs2 (B or B_NEG), Z cleared
  task automatic loadOps(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rSel, input logic [1:0] dSel);
    dpIf.rs1 = a;
    dpIf.rs2 = b;
    applyStimulus(rSel, dSel, 2'd1, 2'd0, 2'd0, 1'b0, 3'd0);
    tick();
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
  endtask

  // Divide iterations: SUB_KEEP, SHR, SHL_ADD
  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(3'd3, 2'd3, 2'd2, 2'd0, 2'd0, 1'b0, 3'd0);
      tick();
    end
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
  endtask

  // SELECT cycle picks Z or R, DONE cycle reads the result through outSel
  task automatic divResult(input logic drSel, input logic [2:0] outSel,
                           input logic [31:0] expected, input string tag);
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, drSel, 3'd0);
    tick();
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, drSel, outSel);
    #1;
    checkOutput(tag, {32'd0, dpIf.pcpi_rd}, {32'd0, expected});
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
  endtask

  // Full multiply: load, SELECT with operand modes, DONE read
  task automatic mulOp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] aSel,
                       input logic [1:0] bSel, input logic [2:0] outSel,
                       input logic [31:0] expected, input string tag);
    loadOps(a, b, 3'd1, 2'd1);
    applyStimulus(3'd0, 2'd0, 2'd0, aSel, bSel, 1'b0, 3'd0);
    tick();
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, outSel);
    #1;
    checkOutput(tag, {32'd0, dpIf.pcpi_rd}, {32'd0, expected});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    dpIf.rs1 = 32'd0;
    dpIf.rs2 = 32'd0;
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
    resetn = 1'b0;
    #12;

    // Reset state seen through every legal read path
    checkOutput("reset_zero", {32'd0, dpIf.pcpi_rd}, 64'd0);
    dpIf.mux_out = 3'd1; #1;
    checkOutput("reset_mult_lower", {32'd0, dpIf.pcpi_rd}, 64'd0);
    dpIf.mux_out = 3'd3; #1;
    checkOutput("reset_div_rem", {32'd0, dpIf.pcpi_rd}, 64'd0);
    dpIf.mux_out = 3'd0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Multiplies
    mulOp(32'd7, 32'd6, 2'd1, 2'd1, 3'd1, 32'd42, "mul_7x6");
    dpIf.mux_out = 3'd5; #1;
    checkOutput("illegal_out5", {32'd0, dpIf.pcpi_rd}, 64'd0);
    mulOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 2'd2, 3'd2, 32'd0, "mulh_m1xm1");
    mulOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 2'd1, 3'd2, 32'hFFFF_FFFE, "mulhu_max");
    mulOp(32'hFFFF_FFFF, 32'd3, 2'd2, 2'd1, 3'd1, 32'hFFFF_FFFD, "mulhsu_lower");
    mulOp(32'hFFFF_FFFF, 32'd3, 2'd2, 2'd1, 3'd2, 32'hFFFF_FFFF, "mulhsu_upper");

    // DIVU / REMU 100 / 7
    loadOps(32'd100, 32'd7, 3'd1, 2'd1);
    iterate(32);
    divResult(1'b1, 3'd3, 32'd14, "divu_100_7");
    divResult(1'b0, 3'd3, 32'd2, "remu_100_7");
    applyStimulus(3'd0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b0, 3'd0);
    tick();
    divResult(1'b1, 3'd3, 32'd14, "illegal_z_holds");

    // DIV / REM -100 / 7
    loadOps(32'hFFFF_FF9C, 32'd7, 3'd2, 2'd1);
    iterate(32);
    divResult(1'b1, 3'd4, 32'hFFFF_FFF2, "div_m100_7");
    divResult(1'b0, 3'd4, 32'hFFFF_FFFE, "rem_m100_7");

    // Divide by zero
    loadOps(32'hFFFF_FFFB, 32'd0, 3'd2, 2'd1);
    iterate(32);
    divResult(1'b1, 3'd4, 32'hFFFF_FFFF, "div_m5_0");
    divResult(1'b0, 3'd4, 32'hFFFF_FFFB, "rem_m5_0");
    loadOps(32'd9, 32'd0, 3'd1, 2'd1);
    iterate(32);
    divResult(1'b1, 3'd3, 32'hFFFF_FFFF, "divu_9_0");

    // Signed overflow 0x80000000 / -1
    loadOps(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 2'd2);
    iterate(32);
    divResult(1'b1, 3'd3, 32'h8000_0000, "div_overflow_q");
    divResult(1'b0, 3'd3, 32'd0, "div_overflow_r");

    // Asynchronous reset in the middle of a division
    loadOps(32'd100, 32'd7, 3'd1, 2'd1);
    iterate(10);
    applyStimulus(3'd3, 2'd3, 2'd2, 2'd1, 2'd1, 1'b1, 3'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midreset_R", dut.r_rem, 64'd0);
    checkOutput("midreset_D", dut.r_div, 64'd0);
    checkOutput("midreset_Z", {32'd0, dut.r_quo}, 64'd0);
    checkOutput("midreset_P", dut.r_prod, 64'd0);
    checkOutput("midreset_rd", {32'd0, dpIf.pcpi_rd}, 64'd0);
    applyStimulus(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    loadOps(32'd100, 32'd7, 3'd1, 2'd1);
    iterate(32);
    divResult(1'b1, 3'd3, 32'd14, "post_reset_divu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
